// File: rtl/sram_pkg.sv
// Shared constants and write-FSM encoding for the pixel-clock SRAM arbiter.
package sram_pkg;
    localparam int DW         = 16;
    localparam int AW_DEFAULT = 18;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_HOLD  = 2'd3
    } wr_state_e;
endpackage

// File: rtl/sram_wr_fifo.sv
// Synchronous host-write FIFO with a registered level and a one-ahead peek so
// the arbiter can chain writes without an idle cycle.
module sram_wr_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 36,
    localparam int PW    = $clog2(DEPTH),
    localparam int LW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [W-1:0]  head_nx,
    output logic [LW-1:0] level
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          do_push, do_pop;

    // A push into a full FIFO is only taken when a slot frees on the same edge.
    always_comb begin
        do_pop   = pop && (level_q != '0);
        do_push  = push && ((level_q != LW'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        level_d  = level_q + LW'(do_push) - LW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    assign head    = mem_q[rd_ptr_q];
    assign head_nx = mem_q[rd_ptr_q + PW'(1)];
    assign level   = level_q;
endmodule

// File: rtl/sram_arb.sv
// Single-port async SRAM arbiter: video reads always win, buffered host writes
// run a 3-cycle SETUP/PULSE/HOLD sequence inside the blanking window.
module sram_arb
    import sram_pkg::*;
#(
    parameter  int FIFO_DEPTH = 4,
    parameter  int AW         = AW_DEFAULT,
    localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          v_req,
    input  logic [AW-1:0] v_addr,
    output logic [DW-1:0] v_data,
    input  logic          wr_allow,
    input  logic          h_valid,
    output logic          h_ready,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_data,
    input  logic [1:0]    h_be,
    inout  wire  [DW-1:0] sram_dq,
    output logic [AW-1:0] sram_addr,
    output logic          sram_ce_n,
    output logic          sram_oe_n,
    output logic          sram_we_n,
    output logic          sram_lb_n,
    output logic          sram_ub_n,
    output logic [LW-1:0] fifo_level,
    output logic          collide
);
    localparam int EW = 2 + AW + DW;

    wr_state_e     state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d, v_data_q, v_data_d;
    logic          ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
    logic          lb_n_q, lb_n_d, ub_n_q, ub_n_d, collide_q, collide_d;
    logic [EW-1:0] head, head_nx, entry;
    logic          push, pop, start;

    assign h_ready = (fifo_level < LW'(FIFO_DEPTH));
    assign push    = h_valid && h_ready;
    assign pop     = (state_q == ST_HOLD) && !v_req;

    sram_wr_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .din     ({h_be, h_addr, h_data}),
        .pop     (pop),
        .head    (head),
        .head_nx (head_nx),
        .level   (fifo_level)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ce_n_d    = ce_n_q;
        oe_n_d    = oe_n_q;
        we_n_d    = we_n_q;
        lb_n_d    = lb_n_q;
        ub_n_d    = ub_n_q;
        collide_d = collide_q;
        v_data_d  = sram_dq;
        // Chaining out of HOLD needs a second entry, since the head pops this edge.
        start = !v_req && wr_allow &&
                (((state_q == ST_IDLE) && (fifo_level != '0)) ||
                 ((state_q == ST_HOLD) && (fifo_level >= LW'(2))));
        entry = pop ? head_nx : head;

        if (v_req) begin
            state_d   = ST_IDLE;
            addr_d    = v_addr;
            {ce_n_d, oe_n_d, we_n_d, lb_n_d, ub_n_d} = 5'b00100;
            collide_d = collide_q || (state_q != ST_IDLE);
        end else if (start) begin
            state_d = ST_SETUP;
            wdata_d = entry[DW-1:0];
            addr_d  = entry[DW +: AW];
            {ce_n_d, oe_n_d, we_n_d} = 3'b011;
            lb_n_d  = ~entry[EW-2];
            ub_n_d  = ~entry[EW-1];
        end else begin
            case (state_q)
                ST_SETUP: begin state_d = ST_PULSE; we_n_d = 1'b0; end
                ST_PULSE: begin state_d = ST_HOLD;  we_n_d = 1'b1; end
                default: begin
                    state_d = ST_IDLE;
                    {ce_n_d, oe_n_d, we_n_d, lb_n_d, ub_n_d} = 5'b11111;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            v_data_q  <= '0;
            {ce_n_q, oe_n_q, we_n_q, lb_n_q, ub_n_q} <= 5'b11111;
            collide_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            v_data_q  <= v_data_d;
            {ce_n_q, oe_n_q, we_n_q, lb_n_q, ub_n_q} <= {ce_n_d, oe_n_d, we_n_d, lb_n_d, ub_n_d};
            collide_q <= collide_d;
        end
    end

    // oe_n is always high in the write states, so the bus never fights the SRAM.
    assign sram_dq   = (state_q != ST_IDLE) ? wdata_q : 'z;
    assign sram_addr = addr_q;
    assign sram_ce_n = ce_n_q;
    assign sram_oe_n = oe_n_q;
    assign sram_we_n = we_n_q;
    assign sram_lb_n = lb_n_q;
    assign sram_ub_n = ub_n_q;
    assign v_data    = v_data_q;
    assign collide   = collide_q;
endmodule

// File: tb/tb_sram_arb.sv
// Randomized bench for sram_arb: SRAM pin model plus an in-order write reference.
module tb_sram_arb;
    logic        clk = 1'b0;
    logic        rst, v_req, wr_allow, h_valid;
    logic [17:0] v_addr, h_addr;
    logic [15:0] h_data, v_data;
    logic [1:0]  h_be;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;
    logic        h_ready, collide;
    logic [2:0]  fifo_level;

    sram_arb dut (
        .clk(clk), .rst(rst), .v_req(v_req), .v_addr(v_addr), .v_data(v_data),
        .wr_allow(wr_allow), .h_valid(h_valid), .h_ready(h_ready),
        .h_addr(h_addr), .h_data(h_data), .h_be(h_be), .sram_dq(sram_dq),
        .sram_addr(sram_addr), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n),
        .fifo_level(fifo_level), .collide(collide)
    );

    always #5 clk = ~clk;

    wire [4:0] ctl = {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n};

    int n_chk = 0, n_pass = 0, we_cnt = 0;
    bit rnd_mode = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                          input logic [1:0] be);
        return {be[1] ? nw[15:8] : old[15:8], be[0] ? nw[7:0] : old[7:0]};
    endfunction

    // SRAM pin model: unwritten words read back as their own address.
    bit [15:0] mem [0:1023];
    bit        mvld[0:1023];
    function automatic logic [15:0] sram_rd(input logic [17:0] a);
        return mvld[a[9:0]] ? mem[a[9:0]] : a[15:0];
    endfunction
    assign sram_dq = (!sram_ce_n && !sram_oe_n) ? sram_rd(sram_addr) : 16'hzzzz;
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            mem[sram_addr[9:0]]  <= merge(sram_rd(sram_addr), sram_dq, ~{sram_ub_n, sram_lb_n});
            mvld[sram_addr[9:0]] <= 1'b1;
            we_cnt               <= we_cnt + 1;
        end
    end

    // Reference: accepted host writes applied in acceptance order.
    bit [15:0] rmem [0:1023];
    bit        rvld[0:1023];
    logic [17:0] touched[$];
    function automatic logic [15:0] ref_rd(input logic [17:0] a);
        return rvld[a[9:0]] ? rmem[a[9:0]] : a[15:0];
    endfunction
    task automatic ref_wr(input logic [17:0] a, input logic [15:0] d, input logic [1:0] be);
        rmem[a[9:0]] = merge(ref_rd(a), d, be);
        rvld[a[9:0]] = 1'b1;
        touched.push_back(a);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic rnd_drive();
        if (rnd_mode) begin
            wr_allow = ($urandom_range(0, 3) != 0);
            v_req    = ($urandom_range(0, 9) == 0);
            v_addr   = 18'($urandom_range(768, 1023));
        end
    endtask

    task automatic push(input logic [17:0] a, input logic [15:0] d, input logic [1:0] be,
                        input bit keep);
        bit acc;
        h_addr = a; h_data = d; h_be = be; h_valid = 1'b1;
        for (int n = 0; n < 300; n++) begin
            acc = h_ready;
            rnd_drive();
            tick();
            if (acc) break;
            if (n == 299) chk("push_timeout", 0, 1);
        end
        h_valid = 1'b0;
        if (keep) ref_wr(a, d, be);
    endtask

    task automatic drain(input int max);
        wr_allow = 1'b1; v_req = 1'b0;
        for (int n = 0; n <= max; n++) begin
            if (fifo_level == 3'd0 && sram_ce_n) break;
            if (n == max) chk("drain_timeout", 0, 1);
            tick();
        end
    endtask

    task automatic wait_we_low();
        for (int n = 0; n <= 20; n++) begin
            if (!sram_we_n) break;
            if (n == 20) chk("we_low_timeout", 0, 1);
            tick();
        end
    endtask

    task automatic check_mem(input string tag);
        foreach (touched[i]) chk(tag, 32'(sram_rd(touched[i])), 32'(ref_rd(touched[i])));
        touched.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [17:0] ra[8];
        logic [17:0] a0, a_col, r_col;
        logic [15:0] d_col;
        int we0, busy;
        bit acc;

        rst = 1'b1; v_req = 0; v_addr = '0; wr_allow = 0; h_valid = 0;
        h_addr = '0; h_data = '0; h_be = '0;
        tick(); tick(); tick();
        chk("rst_ctl", 32'(ctl), 32'h1f);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_ready", 32'(h_ready), 1);
        chk("rst_collide", 32'(collide), 0);
        chk("rst_addr", 32'(sram_addr), 0);
        chk("rst_vdata", 32'(v_data), 0);
        rst = 1'b0;

        // Back-to-back reads: fixed 0x10..0x13 then four random addresses.
        for (int i = 0; i < 8; i++)
            ra[i] = (i < 4) ? 18'(16 + i) : 18'($urandom_range(768, 1023));
        we0 = we_cnt;
        for (int i = 0; i < 9; i++) begin
            v_req = (i < 8);
            if (i < 8) v_addr = ra[i];
            tick();
            if (i < 8) chk("rd_ctl", 32'(ctl), 32'h04);
            if (i >= 1) chk("rd_data", 32'(v_data), 32'(ref_rd(ra[i-1])));
        end
        v_req = 0;
        tick();
        chk("rd_idle_ctl", 32'(ctl), 32'h1f);
        chk("rd_no_we", 32'(we_cnt - we0), 0);

        // Single write with the SETUP/PULSE/HOLD pin sequence.
        wr_allow = 1'b1; we0 = we_cnt;
        push(18'h00100, 16'hBEEF, 2'b11, 1'b1);
        tick();
        chk("wr_setup_ctl", 32'(ctl), 32'h0c);
        chk("wr_setup_addr", 32'(sram_addr), 32'h100);
        chk("wr_setup_dq", 32'(sram_dq), 32'hBEEF);
        tick();
        chk("wr_pulse_ctl", 32'(ctl), 32'h08);
        tick();
        chk("wr_hold_ctl", 32'(ctl), 32'h0c);
        tick();
        chk("wr_done_ctl", 32'(ctl), 32'h1f);
        chk("wr_done_level", 32'(fifo_level), 0);
        chk("wr_one_pulse", 32'(we_cnt - we0), 1);
        chk("wr_beef", 32'(sram_rd(18'h100)), 32'hBEEF);

        // Full FIFO: four parked entries, a fifth that stalls, then 15 busy cycles.
        wr_allow = 1'b0;
        a0 = 18'($urandom_range(256, 767));
        push(a0, 16'($urandom), 2'b11, 1'b1);
        for (int i = 1; i < 4; i++) push(18'(a0 + 18'(i * 3) + 18'd1) & 18'h2ff | 18'h100,
                                        16'($urandom), 2'b11, 1'b1);
        chk("full_ready", 32'(h_ready), 0);
        chk("full_level", 32'(fifo_level), 4);
        h_addr = a0; h_data = 16'($urandom); h_be = 2'b11; h_valid = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("stall_level", 32'(fifo_level), 4);
        chk("stall_ready", 32'(h_ready), 0);
        we0 = we_cnt; busy = 0; wr_allow = 1'b1;
        for (int n = 0; n < 60; n++) begin
            acc = h_valid && h_ready;
            tick();
            if (acc) begin h_valid = 1'b0; ref_wr(h_addr, h_data, h_be); end
            if (!sram_ce_n && sram_oe_n) busy++;
            if (!h_valid && fifo_level == 3'd0 && sram_ce_n) break;
        end
        chk("full_accepted5", 32'(h_valid), 0);
        chk("full_busy_cycles", 32'(busy), 15);
        chk("full_pulses", 32'(we_cnt - we0), 5);
        check_mem("full_mem");

        // Collision: a read arriving during PULSE aborts and the entry retries.
        a_col = 18'($urandom_range(256, 767)); d_col = 16'($urandom);
        r_col = 18'($urandom_range(768, 1023));
        we0 = we_cnt;
        push(a_col, d_col, 2'b11, 1'b1);
        wait_we_low();
        v_req = 1'b1; v_addr = r_col;
        tick();
        v_req = 1'b0;
        chk("col_flag", 32'(collide), 1);
        chk("col_rd_ctl", 32'(ctl), 32'h04);
        chk("col_rd_addr", 32'(sram_addr), 32'(r_col));
        tick();
        chk("col_rd_data", 32'(v_data), 32'(ref_rd(r_col)));
        drain(40);
        chk("col_pulses", 32'(we_cnt - we0), 2);
        chk("col_sticky", 32'(collide), 1);
        check_mem("col_mem");

        // Byte enables: lower byte only over 0xFFFF.
        push(18'h00200, 16'hFFFF, 2'b11, 1'b1);
        push(18'h00200, 16'h1234, 2'b01, 1'b1);
        drain(40);
        chk("be_lower", 32'(sram_rd(18'h200)), 32'hFF34);
        check_mem("be_mem");

        // Random traffic with wr_allow and read interruptions.
        rnd_mode = 1'b1;
        for (int i = 0; i < 40; i++)
            push(18'($urandom_range(256, 767)), 16'($urandom), 2'($urandom), 1'b1);
        rnd_mode = 1'b0;
        drain(600);
        check_mem("rnd_mem");

        // Reset in PULSE discards the entry.
        wr_allow = 1'b1;
        push(18'h002ff, 16'h5A5A, 2'b11, 1'b0);
        wait_we_low();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_ctl", 32'(ctl), 32'h1f);
        chk("mrst_level", 32'(fifo_level), 0);
        chk("mrst_ready", 32'(h_ready), 1);
        chk("mrst_collide", 32'(collide), 0);
        we0 = we_cnt;
        for (int i = 0; i < 6; i++) tick();
        chk("mrst_no_retry", 32'(we_cnt - we0), 0);
        chk("mrst_idle_ctl", 32'(ctl), 32'h1f);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
